// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse key-schedule block: widths,
// FSM encoding, rcon lookup and row-major byte / column-word helpers.
package aes_pkg;

    localparam int KEY_W    = 128;
    localparam int WORD_W   = 32;
    localparam int BYTE_W   = 8;
    localparam int NUM_COLS = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L0   = 3'd1,
        ST_L1   = 3'd2,
        ST_L2   = 3'd3,
        ST_L3   = 3'd4,
        ST_L4   = 3'd5
    } ks_state_e;

    // Out-of-range rounds yield 00 so a stray request still completes.
    function automatic logic [BYTE_W-1:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [BYTE_W-1:0] keyByte(input logic [KEY_W-1:0] key,
                                                  input int row, input int col);
        return key[KEY_W-1-BYTE_W*(NUM_COLS*row+col) -: BYTE_W];
    endfunction

    function automatic logic [WORD_W-1:0] colWord(input logic [KEY_W-1:0] key,
                                                  input int col);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_COLS; i++)
            w[WORD_W-1-BYTE_W*i -: BYTE_W] = keyByte(key, i, col);
        return w;
    endfunction

    function automatic logic [KEY_W-1:0] packCols(input logic [WORD_W-1:0] w0,
                                                  input logic [WORD_W-1:0] w1,
                                                  input logic [WORD_W-1:0] w2,
                                                  input logic [WORD_W-1:0] w3);
        logic [WORD_W-1:0] w [NUM_COLS];
        logic [KEY_W-1:0]  key;
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        w[3] = w3;
        key  = '0;
        for (int c = 0; c < NUM_COLS; c++)
            for (int i = 0; i < NUM_COLS; i++)
                key[KEY_W-1-BYTE_W*(NUM_COLS*i+c) -: BYTE_W] = w[c][WORD_W-1-BYTE_W*i -: BYTE_W];
        return key;
    endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Request/response bundle between the decrypt controller and the
// inverse key-schedule step.
interface inv_key_schedule_if;
    import aes_pkg::*;

    logic             start_in;
    logic [3:0]       round_in;
    logic [KEY_W-1:0] key_in;
    logic [KEY_W-1:0] prev_key_out;
    logic             ready_out;
    logic             busy_out;

    modport master (
        output start_in, round_in, key_in,
        input  prev_key_out, ready_out, busy_out
    );

    modport slave (
        input  start_in, round_in, key_in,
        output prev_key_out, ready_out, busy_out
    );
endinterface

// File: rtl/SBOX_ROM.sv
// Synchronous forward AES S-box ROM, one byte per cycle, active-low read enable.
// Output holds its last value while the enable is inactive.
module SBOX_ROM (
    input  logic       clk,
    input  logic       cs_n_i,
    input  logic [7:0] addr_i,
    output logic [7:0] data_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    always_ff @(posedge clk) begin
        if (!cs_n_i)
            data_o <= SBOX[addr_i];
    end
endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key-expansion step: round key r -> round key r-1 in five
// cycles, with SubWord(RotWord(p3)) read one byte per cycle from the S-box ROM.
module inv_key_schedule
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    inv_key_schedule_if.slave  bus
);
    ks_state_e         state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [3:0]        round_q, round_d;
    logic [BYTE_W-1:0] sb1_q, sb1_d, sb2_q, sb2_d, sb3_q, sb3_d;
    logic [KEY_W-1:0]  prev_key_q, prev_key_d;
    logic              ready_q, ready_d;

    logic              rom_cs_n;
    logic [BYTE_W-1:0] rom_addr;
    logic [BYTE_W-1:0] rom_data;

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] p0, p1, p2, p3;

    SBOX_ROM u_sbox (
        .clk    (clk),
        .cs_n_i (rom_cs_n),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    assign w0 = colWord(key_q, 0);
    assign w1 = colWord(key_q, 1);
    assign w2 = colWord(key_q, 2);
    assign w3 = colWord(key_q, 3);
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    // The last SubWord byte S(a0) is taken straight off the ROM in L4 rather than registered.
    assign p0 = w0 ^ {sb1_q ^ rcon(round_q), sb2_q, sb3_q, rom_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            round_q    <= '0;
            sb1_q      <= '0;
            sb2_q      <= '0;
            sb3_q      <= '0;
            prev_key_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            round_q    <= round_d;
            sb1_q      <= sb1_d;
            sb2_q      <= sb2_d;
            sb3_q      <= sb3_d;
            prev_key_q <= prev_key_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        round_d    = round_q;
        sb1_d      = sb1_q;
        sb2_d      = sb2_q;
        sb3_d      = sb3_q;
        prev_key_d = prev_key_q;
        ready_d    = 1'b0;
        rom_cs_n   = 1'b1;
        rom_addr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_in) begin
                    key_d   = bus.key_in;
                    round_d = bus.round_in;
                    state_d = ST_L0;
                end
            end
            ST_L0: begin
                rom_cs_n = 1'b0;
                rom_addr = p3[23:16];
                state_d  = ST_L1;
            end
            ST_L1: begin
                sb1_d    = rom_data;
                rom_cs_n = 1'b0;
                rom_addr = p3[15:8];
                state_d  = ST_L2;
            end
            ST_L2: begin
                sb2_d    = rom_data;
                rom_cs_n = 1'b0;
                rom_addr = p3[7:0];
                state_d  = ST_L3;
            end
            ST_L3: begin
                sb3_d    = rom_data;
                rom_cs_n = 1'b0;
                rom_addr = p3[31:24];
                state_d  = ST_L4;
            end
            ST_L4: begin
                prev_key_d = packCols(p0, p1, p2, p3);
                ready_d    = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.prev_key_out = prev_key_q;
    assign bus.ready_out    = ready_q;
    assign bus.busy_out     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule: a GF(2^8)-derived reference
// model checked every cycle, plus FIPS-197 vectors and control scenarios.
module tb_inv_key_schedule;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cycleCount;
    bit   checkEn;

    inv_key_schedule_if bus ();

    inv_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCount++;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then the affine map.
    function automatic logic [7:0] sboxModel(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++)
            if (gfMul(x, 8'(b)) == 8'h01) inv = 8'(b);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rconRef(input logic [3:0] r);
        logic [7:0] v;
        if (r < 4'd1 || r > 4'd10) return 8'h00;
        v = 8'h01;
        for (int i = 1; i < int'(r); i++) v = xtime(v);
        return v;
    endfunction

    function automatic logic [127:0] keyFromCols(input logic [31:0] c0, input logic [31:0] c1,
                                                 input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0]  w [4];
        logic [127:0] k;
        w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
        k = '0;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 4; c++)
                k[127-8*(4*i+c) -: 8] = w[c][31-8*i -: 8];
        return k;
    endfunction

    function automatic logic [127:0] invStep(input logic [127:0] k, input logic [3:0] r);
        logic [7:0]   m [4][4];
        logic [7:0]   o [4][4];
        logic [127:0] res;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 4; c++)
                m[i][c] = k[127-8*(4*i+c) -: 8];
        for (int i = 0; i < 4; i++) begin
            o[i][3] = m[i][3] ^ m[i][2];
            o[i][2] = m[i][2] ^ m[i][1];
            o[i][1] = m[i][1] ^ m[i][0];
        end
        for (int i = 0; i < 4; i++)
            o[i][0] = m[i][0] ^ sboxModel(o[(i+1)%4][3]) ^ ((i == 0) ? rconRef(r) : 8'h00);
        res = '0;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 4; c++)
                res[127-8*(4*i+c) -: 8] = o[i][c];
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, actual, expected, cycleCount);
        end
    endtask

    // Cycle-level reference: one request in flight, result five edges after acceptance.
    int           mCount;
    logic [127:0] mPending;
    logic [127:0] mPrev;
    logic         mReady;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mCount = 0;
            mPrev  = '0;
            mReady = 1'b0;
        end else begin
            mReady = 1'b0;
            if (mCount == 0) begin
                if (bus.start_in) begin
                    mPending = invStep(bus.key_in, bus.round_in);
                    mCount   = 5;
                end
            end else begin
                mCount--;
                if (mCount == 0) begin
                    mPrev  = mPending;
                    mReady = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && checkEn) begin
            checkOutput("cyc_ready", 128'(bus.ready_out), 128'(mReady));
            checkOutput("cyc_busy", 128'(bus.busy_out), 128'(mCount != 0));
            checkOutput("cyc_prev_key", bus.prev_key_out, mPrev);
        end
    end

    task automatic applyStimulus(input logic [127:0] key, input logic [3:0] r, input bit guard,
                                 output logic [127:0] got, output int lat);
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.key_in   = key;
        bus.round_in = r;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.start_in = guard && (lat == 2);
            bus.key_in   = {$urandom, $urandom, $urandom, $urandom};
            bus.round_in = 4'($urandom_range(0, 15));
        end while (!bus.ready_out && lat < 20);
        bus.start_in = 1'b0;
        got = bus.prev_key_out;
    endtask

    logic [127:0] k10, k9, k1, k0, kZeroRes, got, rk;
    logic [3:0]   rr;
    int           lat, pulses, lastCyc, steps, extra;

    initial begin
        checks = 0; errors = 0; cycleCount = 0; checkEn = 1'b0;
        bus.start_in = 1'b0; bus.round_in = '0; bus.key_in = '0;
        rst = 1'b1;
        #2 rst = 1'b0;

        k10 = keyFromCols(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);
        k9  = keyFromCols(32'hac7766f3, 32'h19fadc21, 32'h28d12941, 32'h575c006e);
        k1  = keyFromCols(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605);
        k0  = keyFromCols(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
        kZeroRes = keyFromCols(32'h63636363, 32'h0, 32'h0, 32'h0);

        checkOutput("model_sbox_00", 128'(sboxModel(8'h00)), 128'(8'h63));
        checkOutput("model_sbox_53", 128'(sboxModel(8'h53)), 128'(8'hed));
        checkOutput("model_rcon_9", 128'(rconRef(4'd9)), 128'(8'h1b));
        checkOutput("model_rcon_10", 128'(rconRef(4'd10)), 128'(8'h36));
        checkOutput("model_step_10", invStep(k10, 4'd10), k9);
        checkOutput("model_step_1", invStep(k1, 4'd1), k0);

        repeat (2) @(negedge clk);
        checkOutput("reset_prev_key", bus.prev_key_out, 128'h0);
        checkOutput("reset_ready", 128'(bus.ready_out), 128'h0);
        checkOutput("reset_busy", 128'(bus.busy_out), 128'h0);
        rst = 1'b1;
        checkEn = 1'b1;

        $display("[TB] round 10 -> 9");
        applyStimulus(k10, 4'd10, 1'b0, got, lat);
        checkOutput("r10_latency", 128'(lat), 128'(6));
        checkOutput("r10_key", got, k9);

        $display("[TB] round 1 -> 0");
        applyStimulus(k1, 4'd1, 1'b0, got, lat);
        checkOutput("r1_latency", 128'(lat), 128'(6));
        checkOutput("r1_key", got, k0);

        $display("[TB] full chain");
        @(negedge clk);
        bus.start_in = 1'b1; bus.key_in = k10; bus.round_in = 4'd10;
        pulses = 0; lastCyc = 0; steps = 0;
        while (pulses < 10 && steps < 200) begin
            @(negedge clk);
            steps++;
            if (bus.ready_out) begin
                pulses++;
                if (pulses > 1) checkOutput("chain_gap", 128'(cycleCount - lastCyc), 128'(6));
                lastCyc = cycleCount;
                bus.key_in   = bus.prev_key_out;
                bus.round_in = 4'(10 - pulses);
                bus.start_in = (pulses < 10);
            end
        end
        bus.start_in = 1'b0;
        checkOutput("chain_pulses", 128'(pulses), 128'(10));
        checkOutput("chain_final", bus.prev_key_out, k0);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ready_out) extra++;
        end
        checkOutput("chain_no_extra", 128'(extra), 128'(0));

        $display("[TB] busy guard");
        applyStimulus(k10, 4'd10, 1'b1, got, lat);
        checkOutput("guard_latency", 128'(lat), 128'(6));
        checkOutput("guard_key", got, k9);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ready_out) extra++;
        end
        checkOutput("guard_single_pulse", 128'(extra), 128'(0));

        $display("[TB] reset mid-operation");
        @(negedge clk);
        bus.start_in = 1'b1; bus.key_in = k1; bus.round_in = 4'd1;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_prev_key", bus.prev_key_out, 128'h0);
        checkOutput("rst_busy", 128'(bus.busy_out), 128'h0);
        checkOutput("rst_ready", 128'(bus.ready_out), 128'h0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ready_out || bus.busy_out) extra++;
        end
        checkOutput("rst_held_quiet", 128'(extra), 128'(0));
        rst = 1'b1;
        applyStimulus(k1, 4'd1, 1'b0, got, lat);
        checkOutput("rst_after_latency", 128'(lat), 128'(6));
        checkOutput("rst_after_key", got, k0);

        $display("[TB] out-of-range round 0");
        applyStimulus(128'h0, 4'd0, 1'b0, got, lat);
        checkOutput("r0_latency", 128'(lat), 128'(6));
        checkOutput("r0_key", got, kZeroRes);

        $display("[TB] randomized requests");
        for (int n = 0; n < 40; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rr = 4'($urandom_range(0, 15));
            applyStimulus(rk, rr, 1'($urandom_range(0, 1)), got, lat);
            checkOutput("rand_latency", 128'(lat), 128'(6));
            checkOutput("rand_key", got, invStep(rk, rr));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

AES-128 inverse key-expansion step for the decryption datapath. Given the round key for round r (1..10), computes the round key for round r-1 in a fixed 5-cycle sequence, so the decrypt controller can walk from the round-10 key back to the cipher key on the fly. It performs the four SubWord lookups through a synchronous forward S-box ROM, one byte per cycle, and signals completion with a one-cycle `ready_out` pulse.

## Interface
Parameters: none (AES-128 only).

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start_in  input  1  request; sampled only in IDLE.
- round_in  input  4  round index r of `key_in`, valid 1..10; output is key r-1.
- key_in  input  128  round-r key, sampled with `start_in`.
- prev_key_out  output  128  round-(r-1) key, registered, held until the next completion.
- ready_out  output  1  one-cycle pulse: `prev_key_out` updated this cycle.
- busy_out  output  1  high from the accepting edge until the completion edge.

## Operation
- Byte layout, row-major: byte(row i, col c) = key[127-8*(4i+c) -: 8]. Column word wc = {byte(0,c), byte(1,c), byte(2,c), byte(3,c)}.
- Inverse step from input columns w0..w3:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon(r), 24'h0}
- RotWord({a0,a1,a2,a3}) = {a1,a2,a3,a0}. SubWord uses the forward AES S-box, not the inverse.
- rcon(r), for r = 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- Out-of-range r (0 or 11..15): rcon = 00, and the computation still completes. This is not an error indication; the controller must never issue it.
- Inputs are latched at acceptance. `key_in` and `round_in` may change freely while busy.
- FSM states:
  - IDLE: if `start_in`, latch inputs and go to L0.
  - L0: present address a1; go to L1.
  - L1: capture S(a1), present a2; go to L2.
  - L2: capture S(a2), present a3; go to L3.
  - L3: capture S(a3), present a0; go to L4.
  - L4: form p0 using the live ROM data S(a0); register `prev_key_out`, pulse `ready_out`; go to IDLE.
  - Undefined state codes go to IDLE.
- `start_in` outside IDLE is ignored, with no queuing.
- ROM enable is active only in L0..L3. Address is 0 and enable is inactive otherwise.

## Timing
- Reset values:
  - state IDLE
  - prev_key_out = 0, ready_out = 0, busy_out = 0
  - captured S-box bytes 0
  - ROM enable inactive
- Reset is effective immediately on assertion and may occur mid-sequence. It aborts the sequence: no `ready_out` pulse, and `prev_key_out` is cleared to 0.
- Latency: `start_in` sampled at edge E0. `prev_key_out` and `ready_out` are registered at E5, so `ready_out` is high for the single cycle E5..E6.
- ROM read latency is 1 cycle: an address presented before edge En has its data valid after En.
- `busy_out` is high during E0..E5 and low in the `ready_out` cycle.
- Back-to-back: `start_in` held high in the `ready_out` cycle is accepted at E6, giving a throughput of one key per 6 cycles.
- `prev_key_out` is stable at all times except the completion edge.

## Structure
- Shared package `aes_pkg`:
  - rcon lookup function
  - byte(row, col) and column-word pack/unpack functions
  - AES-128 width constants
  - FSM state encoding
- One sub-module, the existing synchronous forward `SBOX_ROM`, instantiated internally with an active-low chip/read enable. This block does not contain the S-box table itself.
- The XOR network is combinational inside this module. Only p0 depends on ROM data, and only at L4.

## Test plan
All values below are column words w0..w3, FIPS-197 Appendix A.1.
- Round 10 → 9: r=10, key = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 → at E5, ready_out=1, prev_key_out = ac7766f3 19fadc21 28d12941 575c006e.
- Round 1 → 0: r=1, key = a0fafe17 88542cb1 23a33939 2a6c7605 → prev_key_out = 2b7e1516 28aed2a6 abf71588 09cf4f3c.
- Full chain: start from the round-10 key and issue 10 back-to-back requests (r=10..1), feeding each output back as the next input → final output is the cipher key above. Check exactly 10 `ready_out` pulses, 6 cycles apart.
- Busy guard: pulse `start_in` again at E2 with a different key, and change `key_in` during L1..L3 → single `ready_out` at E5 with the first request's result. The second start is ignored.
- Reset mid-operation: assert rst during L2 → `prev_key_out`=0, `busy_out`=0, no `ready_out` pulse. A fresh request after release completes normally in 5 cycles.
- Out-of-range r=0: key = all-zero → completes at E5 with rcon=00. Result is p0 = 63636363 and p1 = p2 = p3 = 0.
